pwm_duty_ctrl: RTL and testbench
================================

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: consecutive stable cycles required before a switch value is accepted; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sw_raw  input  4  raw board switches; asynchronous to clk, may bounce.
REQ-005 period_start  input  1  one-cycle pulse from the downstream PWM stage when its period counter wraps to 0.
REQ-006 duty_code  output  4  committed duty code feeding the PWM stage's sw input; changes only on a commit.
REQ-007 duty_upd  output  1  one-cycle pulse in the cycle after duty_code changes.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 sw_raw SHALL pass through a 2-flop synchronizer per bit; sync_q is the second flop, so sync_q lags sw_raw by 2 cycles.
REQ-010 The FSM SHALL have three states: IDLE, SETTLE and PENDING, plus a 4-bit candidate register cand and a debounce counter cnt of width clog2(DEB_CYCLES).
REQ-011 IDLE: if sync_q != cand, load cand <= sync_q, clear cnt, and go to SETTLE; otherwise stay.
REQ-012 SETTLE: if sync_q != cand, reload cand and clear cnt, staying in SETTLE; otherwise increment cnt.
REQ-013 SETTLE exit: when cnt == DEB_CYCLES-1 and sync_q == cand, go to PENDING if cand != duty_code, else go to IDLE with no commit.
REQ-014 PENDING: on period_start, commit (duty_code <= next value per REQ-020), then go to IDLE if the committed value equals cand, else stay in PENDING.
REQ-015 PENDING: if sync_q != cand and period_start is low, discard the pending value, reload cand, clear cnt, and go to SETTLE.
REQ-016 Simultaneous period_start and sync_q change in PENDING: the commit SHALL occur with the old cand; cand reloads, cnt clears, and the FSM goes to SETTLE.
REQ-017 duty_code SHALL never change outside a period_start cycle, so the PWM stage never sees a mid-period glitch.
REQ-018 duty_upd SHALL be registered: high exactly one cycle after any cycle in which duty_code changed, low otherwise.
REQ-019 cnt SHALL saturate at DEB_CYCLES-1 and never wrap.
REQ-020 Without slew, the commit value is cand.
REQ-021 period_start pulses in IDLE or SETTLE SHALL be ignored.

Reset
REQ-022 While rst_n is low, the block SHALL asynchronously hold: duty_code=4'b0000, duty_upd=0, busy=0, state IDLE, cand=0, cnt=0, synchronizer flops=0.
REQ-023 Reset deassertion mid-PENDING or mid-SETTLE SHALL lose the pending value; debounce restarts from sync_q after release.

Configuration
REQ-024 Macro PWM_DUTY_SLEW_EN defined: each commit moves duty_code by exactly +1 or -1 toward cand (unsigned), so reaching cand takes |cand-duty_code| period_start pulses.
REQ-025 Macro PWM_DUTY_SLEW_EN undefined: the commit loads cand directly (REQ-020), and REQ-014 always returns the FSM to IDLE after one commit.

Verification (DEB_CYCLES=8)
REQ-026 Reset, then sw_raw=4'hA held, period_start every 32 cycles -> busy rises at cycle 3; duty_code=4'hA at the first period_start after about 11 cycles; duty_upd pulses once.
REQ-027 sw_raw toggles 4'h3/4'h5 every 4 cycles for 40 cycles, then holds 4'h5 -> no commit during toggling; a single commit of 4'h5 after the hold.
REQ-028 Debounced 4'h7 in PENDING, sw_raw changes to 4'h2 before period_start -> 4'h7 is never committed; 4'h2 is committed after re-settling.
REQ-029 Change to sw_raw in the same cycle as period_start while PENDING with cand=4'h4 -> duty_code=4'h4, FSM goes to SETTLE, and the new value is committed later.
REQ-030 PWM_DUTY_SLEW_EN defined, duty_code=0, sw_raw=4'h3 -> duty_code steps 1, 2, 3 on three successive period_start pulses, with three duty_upd pulses; undefined -> a single step 0 to 3.
REQ-031 rst_n asserted low asynchronously mid-SETTLE (between clock edges) -> all outputs reach reset values immediately; after release, sw_raw equal to the prior duty_code still re-debounces from 0.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: debounces board switches and commits the duty code only on PWM period boundaries (optional PWM_DUTY_SLEW_EN steps by one per period)
module pwm_duty_ctrl #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_raw,
    input  logic       period_start,
    output logic [3:0] duty_code,
    output logic       duty_upd,
    output logic       busy
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;
    logic [1:0] state, state_n;
    logic [3:0] sync_m, sync_q, cand, cand_n, duty_n, next_val;
    logic [CW-1:0] cnt, cnt_n;
    logic changed;
    assign changed = sync_q != cand;
    assign busy = state != IDLE;
`ifdef PWM_DUTY_SLEW_EN
    assign next_val = duty_code < cand ? duty_code + 4'd1 : duty_code > cand ? duty_code - 4'd1 : duty_code;
`else
    assign next_val = cand;
`endif
    // two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_m <= '0;
            sync_q <= '0;
        end else begin
            sync_m <= sw_raw;
            sync_q <= sync_m;
        end
    end
    // debounce/commit FSM; a switch change in PENDING wins the state but never blocks a same-cycle commit
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        duty_n  = duty_code;
        case (state)
            IDLE: begin
                if (changed) begin
                    cand_n  = sync_q;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (changed) begin
                    cand_n = sync_q;
                    cnt_n  = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n = cand != duty_code ? PENDING : IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PENDING: begin
                if (period_start) begin
                    duty_n  = next_val;
                    state_n = next_val == cand ? IDLE : PENDING;
                end
                if (changed) begin
                    cand_n  = sync_q;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state registers; duty_upd flags the cycle the new duty code first appears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            duty_code <= '0;
            duty_upd  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            duty_code <= duty_n;
            duty_upd  <= duty_n != duty_code;
        end
    end
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: directed stimulus with a scoreboard of expected committed duty codes
module tb_pwm_duty_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] sw_raw = 4'h0;
    logic       period_start = 1'b0;
    logic [3:0] duty_code;
    logic       duty_upd;
    logic       busy;
    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];
    logic [3:0] model_dc = 4'h0;
    logic [3:0] last_dc = 4'h0;
    logic       last_ps = 1'b0;

    pwm_duty_ctrl #(.DEB_CYCLES(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .period_start(period_start),
        .duty_code(duty_code),
        .duty_upd(duty_upd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] step_to(input logic [3:0] cur, input logic [3:0] tgt);
`ifdef PWM_DUTY_SLEW_EN
        return cur < tgt ? cur + 4'd1 : cur > tgt ? cur - 4'd1 : cur;
`else
        return tgt;
`endif
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic commit_to(input logic [3:0] tgt);
        for (int k = 0; k < 16 && model_dc != tgt; k++) begin
            model_dc = step_to(model_dc, tgt);
            exp_q.push_back(model_dc);
            period_start = 1'b1;
            wait_cycles(1);
            period_start = 1'b0;
            wait_cycles(1);
        end
        chk("commit_value", duty_code, tgt);
        chk("idle_after_commit", {3'b0, busy}, 4'h0);
    endtask

    // monitor: pops the scoreboard on every duty_upd and flags changes outside a period_start cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            last_dc = duty_code;
            last_ps = 1'b0;
        end else begin
            if (duty_code != last_dc) begin
                tests++;
                if (!last_ps) begin
                    fails++;
                    $display("FAIL glitch: duty_code %h->%h without period_start at %0t", last_dc, duty_code, $time);
                end
            end
            if (duty_upd) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_upd: duty_code %h with empty scoreboard at %0t", duty_code, $time);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (duty_code !== e) begin
                        fails++;
                        $display("FAIL upd_value: got %h expected %h at %0t", duty_code, e, $time);
                    end
                end
            end
            last_dc = duty_code;
            last_ps = period_start;
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_duty", duty_code, 4'h0);
        chk("reset_upd", {3'b0, duty_upd}, 4'h0);
        chk("reset_busy", {3'b0, busy}, 4'h0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);
        // basic debounce and commit of 4'hA
        sw_raw = 4'hA;
        wait_cycles(2);
        chk("busy_before_c3", {3'b0, busy}, 4'h0);
        wait_cycles(1);
        chk("busy_at_c3", {3'b0, busy}, 4'h1);
        wait_cycles(8);
        chk("hold_until_period", duty_code, 4'h0);
        chk("pending_busy", {3'b0, busy}, 4'h1);
        commit_to(4'hA);
        // period_start while idle is ignored
        period_start = 1'b1;
        wait_cycles(1);
        period_start = 1'b0;
        wait_cycles(2);
        chk("idle_ps_ignored", duty_code, 4'hA);
        // exact debounce boundary: ps in the last SETTLE cycle is ignored, the next one commits
        sw_raw = 4'h9;
        wait_cycles(10);
        period_start = 1'b1;
        wait_cycles(1);
        chk("no_early_exit", duty_code, 4'hA);
        model_dc = 4'h9;
        exp_q.push_back(4'h9);
        wait_cycles(1);
        period_start = 1'b0;
        chk("boundary_commit", duty_code, 4'h9);
        wait_cycles(2);
        // bouncing switches never commit
        for (int i = 0; i < 10; i++) begin
            sw_raw = i[0] ? 4'h5 : 4'h3;
            period_start = (i % 3) == 0;
            wait_cycles(1);
            period_start = 1'b0;
            wait_cycles(3);
        end
        chk("no_commit_bounce", duty_code, 4'h9);
        sw_raw = 4'h5;
        wait_cycles(14);
        chk("bounce_pending", {3'b0, busy}, 4'h1);
        commit_to(4'h5);
        // settling back on the current code returns to IDLE without a commit
        sw_raw = 4'h8;
        wait_cycles(4);
        sw_raw = 4'h5;
        wait_cycles(14);
        chk("same_value_idle", {3'b0, busy}, 4'h0);
        chk("same_value_duty", duty_code, 4'h5);
        // pending 4'h7 discarded when the switches move before period_start
        sw_raw = 4'h7;
        wait_cycles(12);
        sw_raw = 4'h2;
        wait_cycles(3);
        chk("discard_resettle", {3'b0, busy}, 4'h1);
        wait_cycles(12);
        chk("discard_no_commit", duty_code, 4'h5);
        commit_to(4'h2);
        // switch change coincides with period_start: old candidate commits, then new one settles
        sw_raw = 4'h4;
        wait_cycles(12);
        sw_raw = 4'h6;
        wait_cycles(2);
        period_start = 1'b1;
        model_dc = step_to(model_dc, 4'h4);
        exp_q.push_back(model_dc);
        wait_cycles(1);
        period_start = 1'b0;
        chk("simul_commit", duty_code, model_dc);
        chk("simul_settle", {3'b0, busy}, 4'h1);
        wait_cycles(12);
        commit_to(4'h6);
        // 0 -> 3 (slewed build steps 1,2,3)
        sw_raw = 4'h0;
        wait_cycles(12);
        commit_to(4'h0);
        sw_raw = 4'h3;
        wait_cycles(12);
        commit_to(4'h3);
        // asynchronous reset mid-SETTLE
        sw_raw = 4'h9;
        wait_cycles(6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_duty", duty_code, 4'h0);
        chk("async_rst_upd", {3'b0, duty_upd}, 4'h0);
        chk("async_rst_busy", {3'b0, busy}, 4'h0);
        model_dc = 4'h0;
        sw_raw = 4'h3;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        chk("post_rst_busy_c2", {3'b0, busy}, 4'h0);
        wait_cycles(1);
        chk("post_rst_busy_c3", {3'b0, busy}, 4'h1);
        wait_cycles(8);
        commit_to(4'h3);
        wait_cycles(3);
        chk("scoreboard_empty", 4'(exp_q.size()), 4'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
